// File: rtl/piezo_pkg.sv
// Shared note codes, tone tables and FSM encoding for the piezo tone driver.
package piezo_pkg;

  localparam int unsigned NOTE_W    = 4;
  localparam int unsigned NUM_NOTES = 8;
  localparam int unsigned NOTE_IDXW = 3;

  // Note codes as delivered by the game controller; everything else is silence.
  typedef enum logic [NOTE_W-1:0] {
    NOTE_SILENT = 4'd0,
    NOTE_C4     = 4'd1,
    NOTE_D4     = 4'd2,
    NOTE_E4     = 4'd3,
    NOTE_F4     = 4'd4,
    NOTE_G4     = 4'd5,
    NOTE_A4     = 4'd6,
    NOTE_B4     = 4'd7,
    NOTE_C5     = 4'd8
  } note_code_t;

  // Scale frequencies in Hz, indexed by (code - NOTE_C4).
  localparam int unsigned NOTE_HZ [NUM_NOTES] = '{262, 294, 330, 349, 392, 440, 494, 523};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TONE  = 2'd1,
    ALERT = 2'd2,
    CLICK = 2'd3
  } state_t;

  // Clock cycles per half period of a square wave at f Hz (truncating).
  function automatic int unsigned half_period(int unsigned clk_hz, int unsigned f);
    return clk_hz / (2 * f);
  endfunction

  // Clock cycles in a duration of ms milliseconds; 64-bit product avoids overflow.
  function automatic int unsigned duration_cycles(int unsigned clk_hz, int unsigned ms);
    longint unsigned prod;
    prod = 64'(clk_hz) * 64'(ms);
    return 32'(prod / 64'd1000);
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic note_valid(logic [NOTE_W-1:0] code);
    return (code >= NOTE_C4) && (code <= NOTE_C5);
  endfunction

endpackage

// File: rtl/piezo_tone_driver_square_wave_div.sv
// Programmable 50% duty square wave: toggles every half_per cycles, restartable.
module square_wave_div #(
  parameter int unsigned HW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          restart,
  input  logic [HW-1:0] half_per,
  output logic          wave
);

  logic [HW-1:0] cnt_q;

  // Half-period counter; a restart or idle period parks it at zero with the wave low.
  always_ff @(posedge clk) begin
    if (reset || restart || !run) begin
      cnt_q <= '0;
      wave  <= 1'b0;
    end else if (cnt_q >= half_per - 1'b1) begin
      cnt_q <= '0;
      wave  <= ~wave;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/piezo_tone_driver.sv
// Piezo buzzer driver: scale tones, miss alert and change click as a square wave.
module piezo_tone_driver
  import piezo_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned ALERT_HZ = 200,
  parameter int unsigned ALERT_MS = 300,
  parameter int unsigned CLICK_HZ = 1000,
  parameter int unsigned CLICK_MS = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] note_in,
  input  logic              miss_in,
  input  logic              change_in,
  input  logic              mute_in,
  output logic              piezo_out,
  output logic              busy_out
);

  localparam int unsigned H_ALERT = half_period(CLK_HZ, ALERT_HZ);
  localparam int unsigned H_CLICK = half_period(CLK_HZ, CLICK_HZ);
  localparam int unsigned H_LOW   = half_period(CLK_HZ, NOTE_HZ[0]);
  localparam int unsigned H_HIGH  = half_period(CLK_HZ, NOTE_HZ[NUM_NOTES-1]);
  localparam int unsigned H_MAX   = max_u(max_u(H_LOW, H_ALERT), H_CLICK);
  localparam int unsigned HW      = (H_MAX > 1) ? $clog2(H_MAX) : 1;
  localparam int unsigned D_ALERT = duration_cycles(CLK_HZ, ALERT_MS);
  localparam int unsigned D_CLICK = duration_cycles(CLK_HZ, CLICK_MS);
  localparam int unsigned D_MAX   = max_u(D_ALERT, D_CLICK);
  localparam int unsigned DW      = (D_MAX > 1) ? $clog2(D_MAX) : 1;

  // Reject parameter sets whose tones cannot be produced at this clock.
  if (H_HIGH < 1 || H_ALERT < 1 || H_CLICK < 1 || D_ALERT < 1 || D_CLICK < 1) begin : g_bad_params
    $error("piezo_tone_driver: tone half period or duration below one clock");
  end

  state_t            state_q, state_d;
  logic [NOTE_W-1:0] note_q;
  logic              miss_q, miss_prev_q, change_q, change_prev_q;
  logic [DW-1:0]     dur_q, dur_d, dur_last_c;
  logic              busy_q;
  logic              restart_c, miss_edge_c, change_edge_c, run_c, wave;
  logic [HW-1:0]     hp_c;
  logic [HW-1:0]     note_hp_tbl [NUM_NOTES];
  logic [NOTE_IDXW-1:0] note_idx_c;

  // Per-note half periods fixed at elaboration.
  for (genvar i = 0; i < NUM_NOTES; i++) begin : g_note_hp
    assign note_hp_tbl[i] = HW'(half_period(CLK_HZ, NOTE_HZ[i]));
  end

  assign miss_edge_c   = miss_q & ~miss_prev_q;
  assign change_edge_c = change_q & ~change_prev_q;
  assign note_idx_c    = NOTE_IDXW'(note_q - NOTE_W'(NOTE_C4));
  assign dur_last_c    = (state_q == ALERT) ? DW'(D_ALERT - 1) : DW'(D_CLICK - 1);
  assign run_c         = (state_q != IDLE);

  // Input registers and edge-detect history.
  always_ff @(posedge clk) begin
    if (reset) begin
      note_q        <= NOTE_SILENT;
      miss_q        <= 1'b0;
      miss_prev_q   <= 1'b0;
      change_q      <= 1'b0;
      change_prev_q <= 1'b0;
    end else begin
      note_q        <= note_in;
      miss_q        <= miss_in;
      miss_prev_q   <= miss_q;
      change_q      <= change_in;
      change_prev_q <= change_q;
    end
  end

  // State, duration counter and busy flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dur_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      busy_q  <= (state_d == ALERT) || (state_d == CLICK);
    end
  end

  // Next state: miss beats change beats note; a note change detected as note_q loads.
  always_comb begin
    state_d   = state_q;
    restart_c = 1'b0;
    dur_d     = '0;
    if (miss_edge_c) begin
      state_d   = ALERT;
      restart_c = 1'b1;
    end else if (change_edge_c && (state_q != ALERT)) begin
      state_d   = CLICK;
      restart_c = 1'b1;
    end else begin
      case (state_q)
        IDLE, TONE: begin
          if (note_in != note_q) begin
            restart_c = 1'b1;
            state_d   = note_valid(note_in) ? TONE : IDLE;
          end
        end
        ALERT, CLICK: begin
          // Return decision uses the note value note_q holds from this edge on.
          if (dur_q == dur_last_c) begin
            restart_c = 1'b1;
            state_d   = note_valid(note_in) ? TONE : IDLE;
          end else begin
            dur_d = dur_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Half period selected by the current state.
  always_comb begin
    hp_c = note_hp_tbl[note_idx_c];
    case (state_q)
      ALERT:   hp_c = HW'(H_ALERT);
      CLICK:   hp_c = HW'(H_CLICK);
      default: hp_c = note_hp_tbl[note_idx_c];
    endcase
  end

  square_wave_div #(.HW(HW)) u_div (
    .clk      (clk),
    .reset    (reset),
    .run      (run_c),
    .restart  (restart_c),
    .half_per (hp_c),
    .wave     (wave)
  );

  // Mute only gates the pin; the divider phase is preserved underneath.
  assign piezo_out = wave & ~mute_in;
  assign busy_out  = busy_q;

endmodule

// File: tb/tb_piezo_tone_driver.sv
// Scoreboard bench for piezo_tone_driver against an event-level tone model.
module tb_piezo_tone_driver;

  localparam int unsigned CLK_HZ   = 8000;
  localparam int unsigned ALERT_HZ = 200;
  localparam int unsigned ALERT_MS = 300;
  localparam int unsigned CLICK_HZ = 1000;
  localparam int unsigned CLICK_MS = 50;
  localparam int TB_NOTE_HZ [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic [3:0] note_in   = 4'd0;
  logic       miss_in   = 1'b0;
  logic       change_in = 1'b0;
  logic       mute_in   = 1'b0;
  logic       piezo_out;
  logic       busy_out;

  piezo_tone_driver #(
    .CLK_HZ  (CLK_HZ),
    .ALERT_HZ(ALERT_HZ),
    .ALERT_MS(ALERT_MS),
    .CLICK_HZ(CLICK_HZ),
    .CLICK_MS(CLICK_MS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .note_in  (note_in),
    .miss_in  (miss_in),
    .change_in(change_in),
    .mute_in  (mute_in),
    .piezo_out(piezo_out),
    .busy_out (busy_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic piezo;
    logic busy;
    int   cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Model: what is sounding (0 silent, 1 note, 2 alert, 3 click) and when it last started.
  int m_mode = 0;
  int m_t0   = 0;
  int m_note = 0;
  int m_m1 = 0, m_m2 = 0, m_c1 = 0, m_c2 = 0;
  int cyc = 0;

  int cur_note = 0, cur_miss = 0, cur_chg = 0, cur_mute = 0;

  function automatic bit is_note(int n);
    return (n >= 1) && (n <= 8);
  endfunction

  function automatic int half_of(int mode, int note);
    if (mode == 2) return CLK_HZ / (2 * ALERT_HZ);
    if (mode == 3) return CLK_HZ / (2 * CLICK_HZ);
    return CLK_HZ / (2 * TB_NOTE_HZ[note - 1]);
  endfunction

  function automatic int dur_of(int mode);
    if (mode == 2) return CLK_HZ * ALERT_MS / 1000;
    return CLK_HZ * CLICK_MS / 1000;
  endfunction

  // Advance the model across one clock edge and queue the output it predicts.
  task automatic model_edge(input int note, input int miss, input int chg, input int mute, input int rst);
    exp_t e;
    bit   miss_rise, chg_rise;
    if (rst != 0) begin
      m_mode = 0; m_note = 0;
      m_m1 = 0; m_m2 = 0; m_c1 = 0; m_c2 = 0;
    end else begin
      miss_rise = (m_m1 != 0) && (m_m2 == 0);
      chg_rise  = (m_c1 != 0) && (m_c2 == 0);
      if (miss_rise) begin
        m_mode = 2; m_t0 = cyc;
      end else if (chg_rise && m_mode != 2) begin
        m_mode = 3; m_t0 = cyc;
      end else if (m_mode <= 1) begin
        if (note != m_note) begin
          m_t0 = cyc; m_mode = is_note(note) ? 1 : 0;
        end
      end else if (cyc - m_t0 == dur_of(m_mode)) begin
        m_t0 = cyc; m_mode = is_note(note) ? 1 : 0;
      end
      m_note = note;
      m_m2 = m_m1; m_m1 = miss;
      m_c2 = m_c1; m_c1 = chg;
    end
    e.busy  = (m_mode >= 2);
    if (m_mode == 0 || mute != 0) e.piezo = 1'b0;
    else e.piezo = (((cyc - m_t0) / half_of(m_mode, m_note)) % 2) == 1;
    e.cyc = cyc;
    sb_q.push_back(e);
    cyc++;
  endtask

  task automatic step(input int rst);
    @(negedge clk);
    note_in   = 4'(cur_note);
    miss_in   = cur_miss[0];
    change_in = cur_chg[0];
    mute_in   = cur_mute[0];
    reset     = rst[0];
    model_edge(cur_note, cur_miss, cur_chg, cur_mute, rst);
    @(posedge clk);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  task automatic pulse_change();
    cur_chg = 1; tick(1); cur_chg = 0;
  endtask

  // Monitor: one DUT output per clock, compared against the oldest prediction.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (piezo_out !== mon_e.piezo) begin
        errors++;
        $display("FAIL piezo_out cyc=%0d got=%b expected=%b", mon_e.cyc, piezo_out, mon_e.piezo);
      end
      checks++;
      if (busy_out !== mon_e.busy) begin
        errors++;
        $display("FAIL busy_out cyc=%0d got=%b expected=%b", mon_e.cyc, busy_out, mon_e.busy);
      end
    end
  end

  initial begin
    // Reset, then A4 steady.
    step(1); step(1); step(1);
    cur_note = 6; tick(60);
    // C4 into its high phase, then jump to C5.
    cur_note = 1; tick(22);
    cur_note = 8; tick(50);
    // E4 with a held miss: one full alert, no retrigger from the level.
    cur_note = 3; tick(30);
    cur_miss = 1; tick(2500);
    cur_miss = 0; tick(10);
    // Click on silence, then a click interrupted by a miss at click cycle 100.
    cur_note = 0; tick(10);
    pulse_change(); tick(420);
    pulse_change(); tick(99);
    cur_miss = 1; tick(2450);
    cur_miss = 0; tick(5);
    // Invalid code, silence, then G4 with mute toggled.
    cur_note = 12; tick(20);
    cur_note = 0; tick(20);
    cur_note = 5; tick(25);
    cur_mute = 1; tick(30);
    cur_mute = 0; tick(30);
    // Change during alert is ignored; reset in the middle of an alert.
    cur_miss = 1; tick(500);
    pulse_change(); tick(500);
    cur_miss = 0; cur_note = 0; step(1);
    cur_note = 2; tick(40);
    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(39, 0) == 0) cur_note = int'($urandom_range(15, 0));
      if ($urandom_range(299, 0) == 0) cur_miss = 1 - cur_miss;
      if ($urandom_range(99, 0) == 0) cur_mute = 1 - cur_mute;
      cur_chg = ($urandom_range(149, 0) == 0) ? 1 : 0;
      step(($urandom_range(1999, 0) == 0) ? 1 : 0);
    end
    cur_chg = 0;
    tick(2);
    // Drain: every prediction must have been consumed within a few cycles.
    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
